// File: rtl/inst_encoder_pkg.sv
// rtl/inst_encoder_pkg.sv - instruction formats, field layout and encode/legality helpers
package inst_encoder_pkg;

  typedef enum logic [1:0] {
    FMT_R = 2'd0,
    FMT_I = 2'd1,
    FMT_M = 2'd2,
    FMT_B = 2'd3
  } fmt_e;

  localparam int WORD_W   = 32;
  localparam int OPC_W    = 7;
  localparam int REG_W    = 5;
  localparam int IMM_W    = 10;
  localparam int OFF_W    = 20;
  localparam int LOW_W    = 15;

  localparam int OPC_LSB  = 25;
  localparam int DST_LSB  = 20;
  localparam int SRC1_LSB = 15;
  localparam int SRC2_LSB = 10;
  localparam int IMM_LSB  = 0;

  localparam logic [OPC_W-1:0] ILLEGAL_OPCODE = 7'h7F;

  // B reuses the dst slot for offset[19:15] so a branch gets a 20-bit displacement
  function automatic logic [WORD_W-1:0] encode(
    input fmt_e              f,
    input logic [OPC_W-1:0]  opcode,
    input logic [REG_W-1:0]  dst,
    input logic [REG_W-1:0]  src1,
    input logic [REG_W-1:0]  src2,
    input logic [IMM_W-1:0]  imm,
    input logic [OFF_W-1:0]  offset
  );
    logic [WORD_W-1:0] word;
    word = '0;
    word[OPC_LSB +: OPC_W]   = opcode;
    word[SRC1_LSB +: REG_W]  = src1;
    case (f)
      FMT_R: begin
        word[DST_LSB +: REG_W]  = dst;
        word[SRC2_LSB +: REG_W] = src2;
      end
      FMT_I: begin
        word[DST_LSB +: REG_W] = dst;
        word[IMM_LSB +: IMM_W] = imm;
      end
      FMT_M: begin
        word[DST_LSB +: REG_W] = dst;
        word[0 +: LOW_W]       = offset[LOW_W-1:0];
      end
      default: begin
        word[DST_LSB +: REG_W] = offset[OFF_W-1:LOW_W];
        word[0 +: LOW_W]       = offset[LOW_W-1:0];
      end
    endcase
    return word;
  endfunction

  function automatic logic is_illegal(
    input fmt_e              f,
    input logic [OPC_W-1:0]  opcode,
    input logic [REG_W-1:0]  src2,
    input logic [IMM_W-1:0]  imm
  );
    return (opcode == ILLEGAL_OPCODE) ||
           ((f == FMT_R) && (imm != '0)) ||
           ((f == FMT_I) && (src2 != '0));
  endfunction

endpackage

// File: rtl/inst_enc_fifo.sv
// rtl/inst_enc_fifo.sv - DEPTH x WIDTH synchronous FIFO with registered storage
module inst_enc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // full is judged before any same-cycle pop, so a full FIFO never writes through
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign full   = (r_count == (AW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign rdata  = r_mem[r_rptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= wdata;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - packs instruction descriptors into 32-bit words and streams them to imem
// Optional descriptor legality check enabled by INST_ENCODER_CHECK_EN.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        dst,
  input  logic [4:0]        src1,
  input  logic [4:0]        src2,
  input  logic [9:0]        imm,
  input  logic [19:0]       offset,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [CNT_W-1:0]  wr_count,
  output logic [7:0]        err_count
);

  logic              w_full;
  logic              w_empty;
  logic              w_accept;
  logic              w_illegal;
  logic              w_push;
  logic              w_pop;
  logic [WORD_W-1:0] w_word;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_wr_count;

  assign w_word   = encode(fmt_e'(fmt), opcode, dst, src1, src2, imm, offset);
  assign in_ready = !w_full;
  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept && !w_illegal;
  assign w_pop    = imem_we && imem_ready;
  assign imem_we  = !w_empty;

  inst_enc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .wdata (w_word),
    .pop   (w_pop),
    .rdata (imem_wdata),
    .full  (w_full),
    .empty (w_empty)
  );

  // start outranks a coincident pop: that word lands at the old address and the bump is lost
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr     <= '0;
      r_wr_count <= '0;
    end else if (start) begin
      r_addr     <= base_addr;
      r_wr_count <= '0;
    end else if (w_pop) begin
      r_addr <= r_addr + ADDR_W'(1);
      if (r_wr_count != '1) r_wr_count <= r_wr_count + CNT_W'(1);
    end
  end

  assign imem_addr = r_addr;
  assign wr_count  = r_wr_count;

`ifdef INST_ENCODER_CHECK_EN
  logic [7:0] r_err_count;

  assign w_illegal = is_illegal(fmt_e'(fmt), opcode, src2, imm);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_count <= '0;
    end else if (w_accept && w_illegal && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`else
  assign w_illegal = 1'b0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - directed self-checking bench for inst_encoder
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  dst;
  logic [4:0]  src1;
  logic [4:0]  src2;
  logic [9:0]  imm;
  logic [19:0] offset;
  logic        imem_we;
  logic        imem_ready;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [15:0] wr_count;
  logic [7:0]  err_count;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] bp_word [5];

  always #5 clk = ~clk;

  inst_encoder #(
    .DEPTH  (4),
    .ADDR_W (10),
    .CNT_W  (16)
  ) dut (
    .clk        (clk),
    .rst        (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .fmt        (fmt),
    .opcode     (opcode),
    .dst        (dst),
    .src1       (src1),
    .src2       (src2),
    .imm        (imm),
    .offset     (offset),
    .imem_we    (imem_we),
    .imem_ready (imem_ready),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .wr_count   (wr_count),
    .err_count  (err_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic desc(input logic v, input logic [1:0] f, input logic [6:0] op,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [9:0] im, input logic [19:0] off);
    in_valid = v;
    fmt      = f;
    opcode   = op;
    dst      = d;
    src1     = s1;
    src2     = s2;
    imm      = im;
    offset   = off;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bp_word[0] = 32'h1400_9000;
    bp_word[1] = 32'h1611_1001;
    bp_word[2] = 32'h1821_9002;
    bp_word[3] = 32'h1A32_1003;
    bp_word[4] = 32'h1C42_FFFF;

    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    imem_ready = 1'b1;
    desc(1'b0, 2'd0, 7'd0, 5'd0, 5'd0, 5'd0, 10'd0, 20'd0);
    step();
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    rst_n = 1'b1;
    step();

    // R-format with start to base 0
    start = 1'b1;
    base_addr = 10'd0;
    desc(1'b1, 2'd0, 7'h01, 5'd3, 5'd4, 5'd5, 10'd0, 20'd0);
    step();
    start = 1'b0;
    in_valid = 1'b0;
    chk("r_we", 32'(imem_we), 32'd1);
    chk("r_wdata", imem_wdata, 32'h0232_1400);
    chk("r_addr", 32'(imem_addr), 32'd0);
    step();
    chk("r_pop_we", 32'(imem_we), 32'd0);
    chk("r_pop_addr", 32'(imem_addr), 32'd1);
    chk("r_pop_cnt", 32'(wr_count), 32'd1);

    // I then B back to back
    desc(1'b1, 2'd1, 7'h02, 5'd1, 5'd2, 5'd0, 10'h3FF, 20'd0);
    step();
    chk("i_wdata", imem_wdata, 32'h0411_03FF);
    chk("i_addr", 32'(imem_addr), 32'd1);
    desc(1'b1, 2'd3, 7'h03, 5'd0, 5'd0, 5'd0, 10'd0, 20'hFFFFF);
    step();
    in_valid = 1'b0;
    chk("b_wdata", imem_wdata, 32'h07F0_7FFF);
    chk("b_addr", 32'(imem_addr), 32'd2);
    chk("b_cnt", 32'(wr_count), 32'd2);
    step();
    chk("b_pop_we", 32'(imem_we), 32'd0);
    chk("b_pop_cnt", 32'(wr_count), 32'd3);

    // back-pressure: fill the FIFO of M-format words
    imem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      desc(1'b1, 2'd2, 7'(10 + k), 5'(k), 5'(k + 1), 5'd0, 10'd0, 20'(32'h1000 + k));
      step();
    end
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    chk("bp_head0", imem_wdata, bp_word[0]);
    desc(1'b1, 2'd2, 7'h0E, 5'd4, 5'd5, 5'd0, 10'd0, 20'hF7FFF);
    step();
    chk("bp_stall_ready", 32'(in_ready), 32'd0);
    chk("bp_stall_addr", 32'(imem_addr), 32'd3);
    chk("bp_stall_head", imem_wdata, bp_word[0]);
    imem_ready = 1'b1;
    step();
    chk("bp_nowt_head", imem_wdata, bp_word[1]);
    chk("bp_nowt_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_head2", imem_wdata, bp_word[2]);
    chk("bp_addr5", 32'(imem_addr), 32'd5);
    step();
    chk("bp_head3", imem_wdata, bp_word[3]);
    step();
    chk("bp_head5", imem_wdata, bp_word[4]);
    step();
    chk("bp_drain_we", 32'(imem_we), 32'd0);
    chk("bp_drain_cnt", 32'(wr_count), 32'd8);
    chk("bp_drain_addr", 32'(imem_addr), 32'd8);

    // address wrap after start at 3FF
    start = 1'b1;
    base_addr = 10'h3FF;
    step();
    start = 1'b0;
    chk("wrap_start_addr", 32'(imem_addr), 32'h3FF);
    chk("wrap_start_cnt", 32'(wr_count), 32'd0);
    desc(1'b1, 2'd1, 7'h01, 5'd0, 5'd0, 5'd0, 10'h001, 20'd0);
    step();
    chk("wrap_a_wdata", imem_wdata, 32'h0200_0001);
    desc(1'b1, 2'd1, 7'h01, 5'd0, 5'd0, 5'd0, 10'h002, 20'd0);
    step();
    in_valid = 1'b0;
    chk("wrap_addr0", 32'(imem_addr), 32'd0);
    chk("wrap_b_wdata", imem_wdata, 32'h0200_0002);
    chk("wrap_cnt", 32'(wr_count), 32'd1);

    // start during a stall
    imem_ready = 1'b0;
    start = 1'b1;
    base_addr = 10'h020;
    step();
    start = 1'b0;
    chk("stall_start_addr", 32'(imem_addr), 32'h020);
    chk("stall_start_cnt", 32'(wr_count), 32'd0);
    chk("stall_start_we", 32'(imem_we), 32'd1);
    imem_ready = 1'b1;
    step();
    chk("stall_rel_addr", 32'(imem_addr), 32'h021);
    chk("stall_rel_cnt", 32'(wr_count), 32'd1);

    // start coincident with a pop
    desc(1'b1, 2'd1, 7'h01, 5'd0, 5'd0, 5'd0, 10'h003, 20'd0);
    step();
    in_valid = 1'b0;
    chk("coin_wdata", imem_wdata, 32'h0200_0003);
    start = 1'b1;
    base_addr = 10'h100;
    step();
    start = 1'b0;
    chk("coin_addr", 32'(imem_addr), 32'h100);
    chk("coin_cnt", 32'(wr_count), 32'd0);
    chk("coin_we", 32'(imem_we), 32'd0);

    // illegal opcode descriptor
    desc(1'b1, 2'd0, 7'h7F, 5'd0, 5'd0, 5'd0, 10'd0, 20'd0);
    step();
    in_valid = 1'b0;
    chk("ill_ready", 32'(in_ready), 32'd1);
`ifdef INST_ENCODER_CHECK_EN
    chk("ill_we", 32'(imem_we), 32'd0);
    chk("ill_err", 32'(err_count), 32'd1);
`else
    chk("ill_we", 32'(imem_we), 32'd1);
    chk("ill_wdata", imem_wdata, 32'hFE00_0000);
    chk("ill_err", 32'(err_count), 32'd0);
`endif
    step();

    // async reset with three entries queued
    imem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      desc(1'b1, 2'd2, 7'(10 + k), 5'(k), 5'(k + 1), 5'd0, 10'd0, 20'(32'h1000 + k));
      step();
    end
    in_valid = 1'b0;
    chk("pre_rst_we", 32'(imem_we), 32'd1);
    chk("pre_rst_head", imem_wdata, bp_word[0]);
    rst_n = 1'b0;
    #1;
    chk("arst_we", 32'(imem_we), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    chk("arst_cnt", 32'(wr_count), 32'd0);
    chk("arst_addr", 32'(imem_addr), 32'd0);
    chk("arst_wdata", imem_wdata, 32'd0);
    rst_n = 1'b1;
    imem_ready = 1'b1;
    step();
    chk("post_rst_we", 32'(imem_we), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
